// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces coin sensors, detects jams, queues coins and paces credit pulses
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          nickel_raw,
    input  logic                          dime_raw,
    input  logic                          accept_en,
    output logic                          nickel_in,
    output logic                          dime_in,
    output logic                          coin_reject,
    output logic                          jam,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(JAM_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, ARMING, HELD, JAMMED, RELEASE} state_t;
    state_t          state [2];
    state_t          state_nx [2];
    logic [CW-1:0]   cnt [2];
    logic [CW-1:0]   cnt_nx [2];
    logic [1:0]      sync1, sync2, ev;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            mem [FIFO_DEPTH];
    logic            single, full, push, pop;
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {dime_raw, nickel_raw};
            sync2 <= sync1;
        end
    end
    // channel 0 is the nickel sensor, channel 1 the dime sensor
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= RELEASE;
                cnt[i]   <= '0;
            end
            jam <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nx[i];
                cnt[i]   <= cnt_nx[i];
            end
            jam <= (state_nx[0] == JAMMED) || (state_nx[1] == JAMMED);
        end
    end
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i]   = cnt[i];
            case (state[i])
                IDLE: if (sync2[i]) begin
                    state_nx[i] = ARMING;
                    cnt_nx[i]   = CW'(1);
                end
                ARMING: if (!sync2[i]) begin
                    state_nx[i] = IDLE;
                    cnt_nx[i]   = '0;
                end else if (cnt[i] + 1'b1 == CW'(DEBOUNCE_CYCLES)) begin
                    state_nx[i] = HELD;
                    cnt_nx[i]   = '0;
                end else cnt_nx[i] = cnt[i] + 1'b1;
                HELD: if (!sync2[i]) begin
                    state_nx[i] = RELEASE;
                    cnt_nx[i]   = '0;
                end else if (cnt[i] + 1'b1 == CW'(JAM_CYCLES)) state_nx[i] = JAMMED;
                else cnt_nx[i] = cnt[i] + 1'b1;
                JAMMED: if (!sync2[i]) begin
                    state_nx[i] = RELEASE;
                    cnt_nx[i]   = '0;
                end
                RELEASE: if (sync2[i]) cnt_nx[i] = '0;
                else if (cnt[i] + 1'b1 == CW'(DEBOUNCE_CYCLES)) begin
                    state_nx[i] = IDLE;
                    cnt_nx[i]   = '0;
                end else cnt_nx[i] = cnt[i] + 1'b1;
                default: begin
                    state_nx[i] = RELEASE;
                    cnt_nx[i]   = '0;
                end
            endcase
        end
    end
    always_comb begin
        for (int i = 0; i < 2; i++)
            ev[i] = (state[i] == ARMING) && sync2[i] && (cnt[i] + 1'b1 == CW'(DEBOUNCE_CYCLES));
    end
    // a full queue still accepts a coin when an entry leaves on the same edge
    assign single = ev[0] ^ ev[1];
    assign full   = fifo_count == (AW + 1)'(FIFO_DEPTH);
    assign pop    = (fifo_count != '0) && accept_en && !(nickel_in || dime_in);
    assign push   = single && (!full || pop);
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            nickel_in   <= 1'b0;
            dime_in     <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_ptr + AW'(pop);
            fifo_count  <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
            nickel_in   <= pop && !mem[rd_ptr];
            dime_in     <= pop && mem[rd_ptr];
            coin_reject <= (&ev) || (single && !push);
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= ev[1];
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed scenarios with a coin scoreboard checked on every credit pulse
module tb_coin_acceptor;
    logic       clock = 1'b0, reset = 1'b0;
    logic       nickel_raw = 1'b0, dime_raw = 1'b0, accept_en = 1'b0;
    logic       nickel_in, dime_in, coin_reject, jam;
    logic [2:0] fifo_count;
    int tests = 0, fails = 0;
    int n_cnt = 0, d_cnt = 0, r_cnt = 0;
    logic q[$];
    logic prev_pulse = 1'b0;
    logic exp_coin;

    always #5 clock = ~clock;

    coin_acceptor dut (
        .clock(clock), .reset(reset), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
        .accept_en(accept_en), .nickel_in(nickel_in), .dime_in(dime_in),
        .coin_reject(coin_reject), .jam(jam), .fifo_count(fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic coin(input logic d);
        if (d) dime_raw = 1'b1; else nickel_raw = 1'b1;
        tick(8);
        nickel_raw = 1'b0;
        dime_raw   = 1'b0;
        tick(8);
    endtask

    // scoreboard: every credit pulse must match the oldest expected coin
    always @(negedge clock) begin
        if (nickel_in || dime_in) begin
            check("pulse_exclusive", {31'b0, nickel_in & dime_in}, 32'd0);
            check("pulse_gap", {31'b0, prev_pulse}, 32'd0);
            if (q.size() == 0) check("unexpected_pulse", q.size(), 32'd1);
            else begin
                exp_coin = q.pop_front();
                check("coin_type", {31'b0, dime_in}, {31'b0, exp_coin});
            end
            if (nickel_in) n_cnt++;
            if (dime_in) d_cnt++;
        end
        if (coin_reject) r_cnt++;
        prev_pulse = nickel_in | dime_in;
    end

    initial begin
        reset = 1'b0;
        tick(3);
        check("rst_nickel", {31'b0, nickel_in}, 0);
        check("rst_dime", {31'b0, dime_in}, 0);
        check("rst_reject", {31'b0, coin_reject}, 0);
        check("rst_jam", {31'b0, jam}, 0);
        check("rst_count", {29'b0, fifo_count}, 0);
        reset = 1'b1;
        accept_en = 1'b1;
        tick(5);

        q.push_back(1'b0);
        nickel_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            if (e >= 6) check($sformatf("lat_edge%0d", e), {31'b0, nickel_in}, {31'b0, e == 7});
        end
        tick(2);
        nickel_raw = 1'b0;
        tick(10);
        check("lat_count_zero", {29'b0, fifo_count}, 0);
        check("lat_no_reject", r_cnt, 0);
        check("lat_no_jam", {31'b0, jam}, 0);
        check("lat_nickels", n_cnt, 1);
        check("lat_sb_empty", q.size(), 0);

        dime_raw = 1'b1; tick(3);
        dime_raw = 1'b0; tick(5);
        dime_raw = 1'b1; tick(3);
        dime_raw = 1'b0; tick(10);
        check("bounce_no_dime", d_cnt, 0);
        check("bounce_no_reject", r_cnt, 0);
        q.push_back(1'b1);
        dime_raw = 1'b1; tick(6);
        dime_raw = 1'b0; tick(10);
        check("debounced_dime", d_cnt, 1);

        accept_en = 1'b0;
        q.push_back(1'b0); coin(1'b0);
        q.push_back(1'b1); coin(1'b1);
        q.push_back(1'b0); coin(1'b0);
        q.push_back(1'b0); coin(1'b0);
        check("fifo_full", {29'b0, fifo_count}, 4);
        coin(1'b1);
        check("full_reject", r_cnt, 1);
        check("full_held", {29'b0, fifo_count}, 4);
        check("disabled_nickels", n_cnt, 1);
        check("disabled_dimes", d_cnt, 1);
        accept_en = 1'b1;
        tick(12);
        check("drain_nickels", n_cnt, 4);
        check("drain_dimes", d_cnt, 2);
        check("drain_count", {29'b0, fifo_count}, 0);
        check("drain_sb_empty", q.size(), 0);

        nickel_raw = 1'b1; dime_raw = 1'b1;
        tick(8);
        nickel_raw = 1'b0; dime_raw = 1'b0;
        tick(10);
        check("simul_reject", r_cnt, 2);
        check("simul_nickels", n_cnt, 4);
        check("simul_dimes", d_cnt, 2);
        check("simul_count", {29'b0, fifo_count}, 0);

        q.push_back(1'b0);
        nickel_raw = 1'b1;
        tick(50);
        check("jam_early", {31'b0, jam}, 0);
        tick(45);
        check("jam_set", {31'b0, jam}, 1);
        tick(5);
        nickel_raw = 1'b0;
        tick(5);
        check("jam_clear", {31'b0, jam}, 0);
        check("jam_coin", n_cnt, 5);
        tick(5);
        q.push_back(1'b0);
        coin(1'b0);
        tick(4);
        check("post_jam_coin", n_cnt, 6);

        accept_en = 1'b0;
        coin(1'b0);
        check("queued_before_rst", {29'b0, fifo_count}, 1);
        nickel_raw = 1'b1;
        reset = 1'b0;
        tick(3);
        check("rst_flush", {29'b0, fifo_count}, 0);
        reset = 1'b1;
        accept_en = 1'b1;
        tick(20);
        check("stuck_no_coin", n_cnt, 6);
        check("stuck_count", {29'b0, fifo_count}, 0);
        nickel_raw = 1'b0;
        tick(6);
        q.push_back(1'b0);
        coin(1'b0);
        tick(4);
        check("rearm_coin", n_cnt, 7);
        check("final_sb_empty", q.size(), 0);
        check("final_rejects", r_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that turns raw, asynchronous, bouncy coin-sensor lines into clean single-cycle nickel_in / dime_in pulses for the item vending FSMs.
- Synchronises and debounces each sensor, and detects jams.
- Queues accepted coins in a small FIFO.
- Releases queued coins one at a time, only while the downstream FSM signals it can accept credit.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples (high or low) required to accept a level change; range 2..15
JAM_CYCLES, 64, cycles a sensor may stay high after a coin is registered before declaring a jam; must exceed DEBOUNCE_CYCLES
FIFO_DEPTH, 4, coin queue entries; power of two, 2..16

Ports:
clock  input  1  rising-edge system clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clock)
nickel_raw  input  1  raw nickel sensor, asynchronous, high while coin in chute
dime_raw  input  1  raw dime sensor, asynchronous, high while coin in chute
accept_en  input  1  downstream may take a coin this cycle
nickel_in  output  1  one-cycle pulse, one nickel credited
dime_in  output  1  one-cycle pulse, one dime credited
coin_reject  output  1  one-cycle pulse, a detected coin was discarded
jam  output  1  level, at least one channel jammed
fifo_count  output  $clog2(FIFO_DEPTH)+1  coins queued

Behaviour:
Reset (reset=0 at a rising edge):
- All outputs 0; FIFO emptied (queued coins lost).
- Synchronisers cleared; debounce counters 0; both channels enter RELEASE.
- A sensor stuck high through reset therefore never creates a coin until it has been low DEBOUNCE_CYCLES.

Synchronisation:
- Each raw line goes through a 2-flop synchroniser. All logic below uses the synchronised value s.

Per-channel FSM, states IDLE, ARMING, HELD, JAMMED, RELEASE:
- IDLE: s=1 -> ARMING, counter=1.
- ARMING: while s=1, counter increments. When counter reaches DEBOUNCE_CYCLES -> HELD and raise a detect event at that edge. s=0 at any point -> IDLE, counter=0 (glitch discarded).
- HELD: counter counts s=1 cycles from entry.
  - s=0 -> RELEASE, counter=0.
  - Counter reaches JAM_CYCLES -> JAMMED.
- JAMMED: jam held high. s=0 -> RELEASE. The coin already registered stays valid.
- RELEASE: needs DEBOUNCE_CYCLES consecutive s=0 to reach IDLE. Any s=1 restarts the count. No event from this state.
- jam = channel0 JAMMED OR channel1 JAMMED (registered).

Event arbitration:
- Both channels raise a detect event on the same edge -> neither coin queued; coin_reject pulses the next cycle.
- An event on one channel while the other is in HELD/JAMMED/RELEASE is a normal coin.

FIFO (1-bit entries, 0=nickel, 1=dime):
- Push on a single detect event.
- If fifo_count==FIFO_DEPTH and no pop that cycle: coin discarded, coin_reject pulses.
- Push and pop in the same cycle are both honoured; fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Output sequencer:
- Pop when fifo_count>0, accept_en=1 and gap=0.
- The popped entry drives nickel_in or dime_in high for exactly the next cycle; gap=1 for that cycle.
- Consequence: at least one low cycle between pulses; nickel_in and dime_in are never high together.
- accept_en=0: no pop. A pulse already launched still completes.

Latency:
- Empty FIFO, accept_en=1, clean input.
- Numbering the first rising edge that samples raw high as edge 1, the output pulse is high after edge DEBOUNCE_CYCLES+3 (edge 7 at default) and low after the next edge.

Reset mid-operation:
- Any in-flight pulse is cut; nothing is emitted until the reset-release rules above are satisfied.

Test Plan:
- Reset, then nickel_raw high 10 cycles, accept_en=1 -> nickel_in high exactly one cycle, after edge 7; fifo_count returns to 0; coin_reject=0, jam=0.
- dime_raw pulses 3 cycles high, then low 5, then high 3 (bounce shorter than DEBOUNCE_CYCLES) -> no dime_in, no coin_reject; then held high 6 cycles -> exactly one dime_in.
- accept_en=0; insert nickel, dime, nickel, nickel, dime (each 8 high / 8 low) -> fifo_count reaches 4; 5th coin gives one coin_reject pulse. Then accept_en=1 -> pulses nickel, dime, nickel, nickel, each separated by at least 1 low cycle; fifo_count ends at 0.
- nickel_raw and dime_raw rise on the same cycle and hold 8 cycles -> coin_reject pulses once; no nickel_in/dime_in; fifo_count stays 0.
- nickel_raw held high 100 cycles -> one nickel_in; jam=1 from HELD-entry+64; jam=0 after raw low; next nickel after 4+ low cycles is accepted.
- nickel_raw held high across reset=0 for 3 cycles and reset release -> no nickel_in until raw goes low ≥4 cycles and rises again; queued coins present at reset are never emitted.
